// File: rtl/latch_mon_pkg.sv
// Shared types and default parameters for the latch output monitor.
package latch_mon_pkg;

  // Glitch filter states
  typedef enum logic [1:0] {
    LO     = 2'd0,
    CHK_HI = 2'd1,
    HI     = 2'd2,
    CHK_LO = 2'd3
  } filt_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILT_LEN    = 4;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/q_glitch_filter.sv
// Synchronizes the asynchronous latch output into clk and debounces it.
//
// state  | meaning
// -------+------------------------------------------------------------
// LO     | filtered level is 0, synchronized input agrees
// CHK_HI | filtered level is 0, counting consecutive 1 samples
// HI     | filtered level is 1, synchronized input agrees
// CHK_LO | filtered level is 1, counting consecutive 0 samples
module q_glitch_filter
  import latch_mon_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_LEN    = DEF_FILT_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic q_in,
  output logic q_filt,
  output logic rise,
  output logic fall
);

  localparam int STAB_W = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   q_sync;

  filt_state_e            state_q, state_d;
  logic [STAB_W-1:0]      stab_q, stab_d;
  logic [STAB_W-1:0]      stab_inc;
  logic                   stab_done;
  logic                   q_filt_q, q_filt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Shift the raw input through the synchronizer chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], q_in};
  end

  assign q_sync    = sync_q[SYNC_STAGES-1];
  assign stab_inc  = stab_q + STAB_W'(1);
  assign stab_done = (stab_inc == STAB_W'(FILT_LEN));

  // Filter next-state: a level change is accepted only after FILT_LEN equal samples
  always_comb begin
    state_d  = state_q;
    stab_d   = stab_q;
    q_filt_d = q_filt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    case (state_q)
      LO: begin
        if (q_sync) begin
          if (FILT_LEN == 1) begin
            state_d  = HI;
            stab_d   = '0;
            q_filt_d = 1'b1;
            rise_d   = 1'b1;
          end else begin
            state_d = CHK_HI;
            stab_d  = STAB_W'(1);
          end
        end
      end
      CHK_HI: begin
        if (!q_sync) begin
          state_d = LO;
          stab_d  = '0;
        end else if (stab_done) begin
          state_d  = HI;
          stab_d   = '0;
          q_filt_d = 1'b1;
          rise_d   = 1'b1;
        end else begin
          stab_d = stab_inc;
        end
      end
      HI: begin
        if (!q_sync) begin
          if (FILT_LEN == 1) begin
            state_d  = LO;
            stab_d   = '0;
            q_filt_d = 1'b0;
            fall_d   = 1'b1;
          end else begin
            state_d = CHK_LO;
            stab_d  = STAB_W'(1);
          end
        end
      end
      CHK_LO: begin
        if (q_sync) begin
          state_d = HI;
          stab_d  = '0;
        end else if (stab_done) begin
          state_d  = LO;
          stab_d   = '0;
          q_filt_d = 1'b0;
          fall_d   = 1'b1;
        end else begin
          stab_d = stab_inc;
        end
      end
      default: begin
        state_d  = LO;
        stab_d   = '0;
        q_filt_d = 1'b0;
      end
    endcase
  end

  // State, synchronizer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      state_q  <= LO;
      stab_q   <= '0;
      q_filt_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      stab_q   <= stab_d;
      q_filt_q <= q_filt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign q_filt = q_filt_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/latch_q_monitor.sv
// Latch output monitor: filtered level, edge events, saturating event
// counters and a snapshot readout handshake.
module latch_q_monitor
  import latch_mon_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_LEN    = DEF_FILT_LEN,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_in,
  input  logic             clr,
  input  logic             snap_req,
  input  logic             snap_ack,
  output logic             q_filt,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             ovf,
  output logic             snap_valid,
  output logic [CNT_W-1:0] snap_rise,
  output logic [CNT_W-1:0] snap_fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             rise_ev, fall_ev;
  logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
  logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;
  logic             ovf_q, ovf_d;
  logic             snap_valid_q, snap_valid_d;
  logic [CNT_W-1:0] snap_rise_q, snap_rise_d;
  logic [CNT_W-1:0] snap_fall_q, snap_fall_d;
  logic             snap_take;

  q_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_filt (
    .clk    (clk),
    .rst    (rst),
    .q_in   (q_in),
    .q_filt (q_filt),
    .rise   (rise_ev),
    .fall   (fall_ev)
  );

  // Saturating event counters; clr overrides any event in the same cycle
  always_comb begin
    rise_cnt_d = rise_cnt_q;
    fall_cnt_d = fall_cnt_q;
    ovf_d      = ovf_q;
    if (clr) begin
      rise_cnt_d = '0;
      fall_cnt_d = '0;
      ovf_d      = 1'b0;
    end else begin
      if (rise_ev) begin
        if (rise_cnt_q == CNT_MAX) begin
          ovf_d = 1'b1;
        end else begin
          rise_cnt_d = rise_cnt_q + CNT_W'(1);
        end
      end
      if (fall_ev) begin
        if (fall_cnt_q == CNT_MAX) begin
          ovf_d = 1'b1;
        end else begin
          fall_cnt_d = fall_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Snapshot captures pre-update counter values; a request against an
  // unacknowledged snapshot is dropped so the consumer sees stable data
  always_comb begin
    snap_take    = snap_req && (!snap_valid_q || snap_ack);
    snap_valid_d = snap_valid_q;
    snap_rise_d  = snap_rise_q;
    snap_fall_d  = snap_fall_q;
    if (snap_take) begin
      snap_valid_d = 1'b1;
      snap_rise_d  = rise_cnt_q;
      snap_fall_d  = fall_cnt_q;
    end else if (snap_ack) begin
      snap_valid_d = 1'b0;
    end
  end

  // Counter and snapshot registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_cnt_q   <= '0;
      fall_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_rise_q  <= '0;
      snap_fall_q  <= '0;
    end else begin
      rise_cnt_q   <= rise_cnt_d;
      fall_cnt_q   <= fall_cnt_d;
      ovf_q        <= ovf_d;
      snap_valid_q <= snap_valid_d;
      snap_rise_q  <= snap_rise_d;
      snap_fall_q  <= snap_fall_d;
    end
  end

  assign rise       = rise_ev;
  assign fall       = fall_ev;
  assign rise_cnt   = rise_cnt_q;
  assign fall_cnt   = fall_cnt_q;
  assign ovf        = ovf_q;
  assign snap_valid = snap_valid_q;
  assign snap_rise  = snap_rise_q;
  assign snap_fall  = snap_fall_q;

endmodule
